frame_rd_axis: RTL

FRAME_RD_AXIS -- requirements
Module: frame_rd_axis

---
 rtl/frame_rd_pkg.sv | 24 ++
 rtl/frame_rd_buf.sv | 66 ++++++
 rtl/frame_rd_axis.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_rd_pkg
//  Description : Shared constants for the frame reader: FSM state encoding
//                and the byte/keep-mask width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_rd_pkg;

    // Reader FSM state encoding
    localparam int              c_state_w = 1;
    localparam logic [c_state_w-1:0] c_st_idle = 1'b0;
    localparam logic [c_state_w-1:0] c_st_read = 1'b1;

    // Bits per byte lane of the data bus
    localparam int c_byte_bits = 8;

    // Number of tkeep bits (byte lanes) for a given data width
    function automatic int keep_width(input int data_width);
        return data_width / c_byte_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_rd_buf.sv
`default_nettype none
// ============================================================================
//  Module      : frame_rd_buf
//  Description : Synchronous FIFO holding output beats, with occupancy count.
//                Storage is cleared on reset so the read port shows zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_rd_buf
    import frame_rd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_full   = (c_addr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                w_wr;
    logic                w_rd;

    // Writes into a full buffer and reads from an empty one are dropped
    assign w_wr = wr_en && (r_count != c_full);
    assign w_rd = rd_en && (r_count != '0);

    // Storage, pointers (wrap naturally at DEPTH) and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (c_addr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_addr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/frame_rd_axis.sv
`default_nettype none
// ============================================================================
//  Module      : frame_rd_axis
//  Description : Reads length-tagged frames from an upstream buffer one beat
//                per strobe and emits them as an AXI-Stream master.
//                Optional macro FRAME_RD_STATS_EN adds frame/byte counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_rd_axis
    import frame_rd_pkg::*;
#(
    parameter int FRAME_DATA_WIDTH = 512,
    parameter int LEN_WIDTH        = 16,
    parameter int TAG_WIDTH        = 8,
    parameter int FRAME_PIPELINE   = 1,
    parameter int OUT_DEPTH        = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   read_frame_ready,
    input  logic [LEN_WIDTH-1:0]                   read_frame_len,
    input  logic [TAG_WIDTH-1:0]                   read_frame_tag,
    output logic                                   read_frame_enb,
    input  logic [FRAME_DATA_WIDTH-1:0]            read_frame_tdata,
    output logic [FRAME_DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [FRAME_DATA_WIDTH/c_byte_bits-1:0] m_axis_tkeep,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tlast,
    output logic [TAG_WIDTH-1:0]                   m_axis_tid,
    output logic [LEN_WIDTH-1:0]                   m_axis_tdest,
    output logic                                   busy
`ifdef FRAME_RD_STATS_EN
    ,
    output logic [31:0]                            stat_frame_cnt,
    output logic [31:0]                            stat_byte_cnt
`endif
);

    localparam int c_bpb    = keep_width(FRAME_DATA_WIDTH);
    localparam int c_beat_w = LEN_WIDTH + 1;
    localparam int c_lvl_w  = $clog2(OUT_DEPTH) + 2;
    localparam int c_side_w = 1 + c_bpb + TAG_WIDTH + LEN_WIDTH;
    localparam int c_buf_w  = FRAME_DATA_WIDTH + c_side_w;

    logic [c_state_w-1:0]       r_state;
    logic [LEN_WIDTH-1:0]       r_len;
    logic [TAG_WIDTH-1:0]       r_tag;
    logic [c_beat_w-1:0]        r_beats;

    logic [c_beat_w-1:0]        w_beats;
    logic [LEN_WIDTH-1:0]       w_rem;
    logic [c_bpb-1:0]           w_keep_last;
    logic                       w_last_now;
    logic [c_side_w-1:0]        w_side_now;
    logic                       w_enb;
    logic [c_lvl_w-1:0]         w_inflight;
    logic [c_lvl_w-1:0]         w_level;
    logic [$clog2(OUT_DEPTH):0] w_occ;
    logic                       w_arr_valid;
    logic [c_side_w-1:0]        w_arr_side;
    logic [c_buf_w-1:0]         w_rd_data;

    // Beat count of the pending frame: ceil(len / bytes-per-beat)
    assign w_beats = ({1'b0, read_frame_len} + c_beat_w'(c_bpb - 1)) / c_beat_w'(c_bpb);

    // Final-beat keep mask: low (len mod bytes-per-beat) lanes, or all lanes
    assign w_rem = r_len % LEN_WIDTH'(c_bpb);
    always_comb begin
        w_keep_last = '0;
        for (int i = 0; i < c_bpb; i++) begin
            w_keep_last[i] = (w_rem == '0) || (LEN_WIDTH'(i) < w_rem);
        end
    end

    // Strobe a beat only while the buffer can absorb everything already requested
    assign w_level = c_lvl_w'(w_occ) + w_inflight;
    assign w_enb   = (r_state == c_st_read) && (w_level < c_lvl_w'(OUT_DEPTH));
    assign read_frame_enb = w_enb;

    assign w_last_now = (r_beats == c_beat_w'(1));
    assign w_side_now = {w_last_now, (w_last_now ? w_keep_last : {c_bpb{1'b1}}), r_tag, r_len};

    // Frame sequencer: latch a non-empty frame, then count its beats down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_len   <= '0;
            r_tag   <= '0;
            r_beats <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (read_frame_ready && (read_frame_len != '0)) begin
                        r_len   <= read_frame_len;
                        r_tag   <= read_frame_tag;
                        r_beats <= w_beats;
                        r_state <= c_st_read;
                    end
                end
                c_st_read: begin
                    if (w_enb) begin
                        r_beats <= r_beats - c_beat_w'(1);
                        if (w_last_now) begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Sideband travels alongside the upstream read latency
    generate
        if (FRAME_PIPELINE == 0) begin : g_pipe_none
            assign w_arr_valid = w_enb;
            assign w_arr_side  = w_side_now;
            assign w_inflight  = '0;
        end else begin : g_pipe_shift
            logic [FRAME_PIPELINE-1:0] r_pv;
            logic [c_side_w-1:0]       r_ps [FRAME_PIPELINE];
            logic [c_lvl_w-1:0]        w_pop;

            // Shift strobe valid and sideband one stage per cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pv <= '0;
                    for (int i = 0; i < FRAME_PIPELINE; i++) begin
                        r_ps[i] <= '0;
                    end
                end else begin
                    r_pv[0] <= w_enb;
                    r_ps[0] <= w_side_now;
                    for (int i = 1; i < FRAME_PIPELINE; i++) begin
                        r_pv[i] <= r_pv[i-1];
                        r_ps[i] <= r_ps[i-1];
                    end
                end
            end

            // Number of requested beats not yet written to the buffer
            always_comb begin
                w_pop = '0;
                for (int i = 0; i < FRAME_PIPELINE; i++) begin
                    w_pop = w_pop + c_lvl_w'(r_pv[i]);
                end
            end

            assign w_inflight  = w_pop;
            assign w_arr_valid = r_pv[FRAME_PIPELINE-1];
            assign w_arr_side  = r_ps[FRAME_PIPELINE-1];
        end
    endgenerate

    frame_rd_buf #(
        .WIDTH (c_buf_w),
        .DEPTH (OUT_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_arr_valid),
        .wr_data ({w_arr_side, read_frame_tdata}),
        .rd_en   (m_axis_tvalid && m_axis_tready),
        .rd_data (w_rd_data),
        .count   (w_occ)
    );

    assign m_axis_tvalid = (w_occ != '0);
    assign m_axis_tdata  = w_rd_data[FRAME_DATA_WIDTH-1:0];
    assign m_axis_tdest  = w_rd_data[FRAME_DATA_WIDTH +: LEN_WIDTH];
    assign m_axis_tid    = w_rd_data[FRAME_DATA_WIDTH + LEN_WIDTH +: TAG_WIDTH];
    assign m_axis_tkeep  = w_rd_data[FRAME_DATA_WIDTH + LEN_WIDTH + TAG_WIDTH +: c_bpb];
    assign m_axis_tlast  = w_rd_data[c_buf_w-1];

    assign busy = (r_state == c_st_read) || (w_inflight != '0) || (w_occ != '0);

`ifdef FRAME_RD_STATS_EN
    logic [31:0] r_stat_frame_cnt;
    logic [31:0] r_stat_byte_cnt;
    logic        w_last_hs;

    assign w_last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Count delivered frames and their byte lengths (wrapping)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_frame_cnt <= '0;
            r_stat_byte_cnt  <= '0;
        end else if (w_last_hs) begin
            r_stat_frame_cnt <= r_stat_frame_cnt + 32'd1;
            r_stat_byte_cnt  <= r_stat_byte_cnt + 32'(m_axis_tdest);
        end
    end

    assign stat_frame_cnt = r_stat_frame_cnt;
    assign stat_byte_cnt  = r_stat_byte_cnt;
`endif

endmodule
`default_nettype wire
